// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: word RAM with sub-word read-modify-write,
// extended load responses and a store commit trace.
module dmem_responder #(
  parameter int XLEN = 32,
  parameter int AW   = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_swhb,
  input  logic [1:0]      req_lwhb,
  input  logic            req_lunsigned,
  input  logic [XLEN-1:0] req_pc,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            wtrace_valid,
  output logic [XLEN-1:0] wtrace_pc,
  output logic [XLEN-1:0] wtrace_addr,
  output logic [XLEN-1:0] wtrace_data
);

  // Handshake: a request transfers on the rising edge where req_valid & req_ready;
  // fields are captured there and the requester holds the request until then.
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_RMW_WR, S_ERR} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_mem [0:(1<<AW)-1];
  logic [XLEN-1:0] r_rd_data;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [1:0]      r_size;
  logic            r_lunsigned;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rdata_last;
  logic            r_wtrace_valid;
  logic [XLEN-1:0] r_wtrace_pc;
  logic [XLEN-1:0] r_wtrace_addr;
  logic [XLEN-1:0] r_wtrace_data;

  logic            w_accept;
  logic [1:0]      w_size;
  logic            w_misalign;
  logic [AW-1:0]   w_idx;
  logic [AW-1:0]   w_r_idx;
  logic [4:0]      w_shift;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_load_ext;
  logic [XLEN-1:0] w_base_mask;
  logic [XLEN-1:0] w_mask;
  logic [XLEN-1:0] w_merged;
  logic            w_word_store;

  assign req_ready    = (r_state == S_IDLE) & ~reset;
  assign w_accept     = req_valid & req_ready;
  assign w_size       = req_we ? req_swhb : req_lwhb;
  assign w_misalign   = (w_size == 2'b11) |
                        ((w_size == 2'b01) & req_addr[0]) |
                        ((w_size == 2'b00) & (|req_addr[1:0]));
  assign w_idx        = req_addr[AW+1:2];
  assign w_r_idx      = r_addr[AW+1:2];
  assign w_word_store = w_accept & req_we & (w_size == 2'b00) & ~w_misalign;

  assign w_shift      = {r_addr[1:0], 3'b000};
  assign w_lane       = r_rd_data >> w_shift;
  assign w_base_mask  = (r_size == 2'b10) ? {{(XLEN-8){1'b0}}, 8'hFF}
                                          : {{(XLEN-16){1'b0}}, 16'hFFFF};
  assign w_mask       = w_base_mask << w_shift;
  assign w_merged     = (r_rd_data & ~w_mask) | ((r_wdata << w_shift) & w_mask);

  always_comb begin
    w_load_ext = w_lane;
    case (r_size)
      2'b10: w_load_ext = r_lunsigned ? {{(XLEN-8){1'b0}}, w_lane[7:0]}
                                      : {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
      2'b01: w_load_ext = r_lunsigned ? {{(XLEN-16){1'b0}}, w_lane[15:0]}
                                      : {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      default: w_load_ext = w_lane;
    endcase
  end

  // RAM is not reset; a pending RMW write is dropped if reset arrives in RMW_WR.
  always_ff @(posedge clk) begin
    if (w_word_store)
      r_mem[w_idx] <= req_wdata;
    else if (!reset && r_state == S_RMW_WR)
      r_mem[w_r_idx] <= w_merged;
    if (w_accept)
      r_rd_data <= r_mem[w_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_size         <= 2'b00;
      r_lunsigned    <= 1'b0;
      r_pc           <= '0;
      r_rdata_last   <= '0;
      r_wtrace_valid <= 1'b0;
      r_wtrace_pc    <= '0;
      r_wtrace_addr  <= '0;
      r_wtrace_data  <= '0;
    end else begin
      r_wtrace_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_size      <= w_size;
            r_lunsigned <= req_lunsigned;
            r_pc        <= req_pc;
            if (w_misalign)
              r_state <= S_ERR;
            else if (!req_we)
              r_state <= S_LOAD;
            else if (w_size == 2'b00) begin
              r_wtrace_valid <= 1'b1;
              r_wtrace_pc    <= req_pc;
              r_wtrace_addr  <= {req_addr[XLEN-1:2], 2'b00};
              r_wtrace_data  <= req_wdata;
            end else
              r_state <= S_RMW_RD;
          end
        end
        S_LOAD: begin
          r_rdata_last <= w_load_ext;
          r_state      <= S_IDLE;
        end
        S_RMW_RD: r_state <= S_RMW_WR;
        S_RMW_WR: begin
          r_wtrace_valid <= 1'b1;
          r_wtrace_pc    <= r_pc;
          r_wtrace_addr  <= {r_addr[XLEN-1:2], 2'b00};
          r_wtrace_data  <= w_merged;
          r_state        <= S_IDLE;
        end
        S_ERR: begin
          if (!r_we) r_rdata_last <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Responses are decoded from the registered state so they are exactly one cycle wide.
  assign resp_valid   = (r_state == S_LOAD) | ((r_state == S_ERR) & ~r_we);
  assign resp_err     = (r_state == S_ERR);
  assign resp_rdata   = (r_state == S_LOAD) ? w_load_ext :
                        ((r_state == S_ERR) & ~r_we) ? '0 : r_rdata_last;
  assign wtrace_valid = r_wtrace_valid;
  assign wtrace_pc    = r_wtrace_pc;
  assign wtrace_addr  = r_wtrace_addr;
  assign wtrace_data  = r_wtrace_data;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic against a
// byte-lane memory model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_swhb;
  logic [1:0]  req_lwhb;
  logic        req_lunsigned;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        wtrace_valid;
  logic [31:0] wtrace_pc;
  logic [31:0] wtrace_addr;
  logic [31:0] wtrace_data;

  dmem_responder #(.XLEN(32), .AW(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_swhb(req_swhb),
    .req_lwhb(req_lwhb), .req_lunsigned(req_lunsigned), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .wtrace_valid(wtrace_valid), .wtrace_pc(wtrace_pc),
    .wtrace_addr(wtrace_addr), .wtrace_data(wtrace_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [1024];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int model_idx(input logic [31:0] addr);
    return int'((addr >> 2) % 1024);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns);
    logic [31:0] w;
    logic [31:0] v;
    int off;
    w   = model_mem[model_idx(addr)];
    off = int'(addr % 4);
    if (size == 2'd0) return w;
    if (size == 2'd1) begin
      v = (w >> (8 * off)) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = (w >> (8 * off)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] addr, input logic [31:0] data,
                                              input logic [1:0] size);
    logic [7:0] b [4];
    logic [31:0] w;
    int off;
    int nb;
    w   = model_mem[model_idx(addr)];
    off = int'(addr % 4);
    nb  = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
    for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
    for (int k = 0; k < nb; k++) b[off + k] = data[8*k +: 8];
    w = {b[3], b[2], b[1], b[0]};
    model_mem[model_idx(addr)] = w;
    return w;
  endfunction

  task automatic scramble_inputs();
    req_valid     = 1'b0;
    req_we        = 1'($urandom);
    req_addr      = $urandom;
    req_wdata     = $urandom;
    req_swhb      = 2'($urandom);
    req_lwhb      = 2'($urandom);
    req_lunsigned = 1'($urandom);
    req_pc        = $urandom;
  endtask

  // driver: called just after a falling edge; returns just after a falling edge
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input logic [31:0] pc);
    bit err;
    int waited;
    logic [31:0] exp_word;
    logic [31:0] exp_rd;
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd0 && addr % 4 != 0);
    req_valid     = 1'b1;
    req_we        = we;
    req_addr      = addr;
    req_wdata     = wdata;
    req_swhb      = we ? size : 2'($urandom);
    req_lwhb      = we ? 2'($urandom) : size;
    req_lunsigned = uns;
    req_pc        = pc;
    #1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    scramble_inputs();
    #1;
    if (err) begin
      check("err_pulse", 32'(resp_err), 32'd1);
      check("err_resp_valid", 32'(resp_valid), 32'(!we));
      if (!we) check("err_rdata", resp_rdata, 32'd0);
      check("err_no_trace", 32'(wtrace_valid), 32'd0);
      @(negedge clk); #1;
      check("err_single", 32'(resp_err), 32'd0);
      check("err_ready_back", 32'(req_ready), 32'd1);
    end else if (!we) begin
      exp_q.push_back(model_load(addr, size, uns));
      check("ld_valid", 32'(resp_valid), 32'd1);
      check("ld_err", 32'(resp_err), 32'd0);
      check("ld_ready_low", 32'(req_ready), 32'd0);
      exp_rd = exp_q.pop_front();
      check("ld_data", resp_rdata, exp_rd);
      @(negedge clk); #1;
      check("ld_single", 32'(resp_valid), 32'd0);
      check("ld_hold", resp_rdata, exp_rd);
    end else if (size == 2'd0) begin
      exp_word = model_store(addr, wdata, size);
      check("sw_trace_valid", 32'(wtrace_valid), 32'd1);
      check("sw_trace_pc", wtrace_pc, pc);
      check("sw_trace_addr", wtrace_addr, addr & 32'hFFFFFFFC);
      check("sw_trace_data", wtrace_data, exp_word);
      check("sw_ready", 32'(req_ready), 32'd1);
    end else begin
      exp_word = model_store(addr, wdata, size);
      check("rmw_ready_low1", 32'(req_ready), 32'd0);
      check("rmw_no_trace1", 32'(wtrace_valid), 32'd0);
      @(negedge clk); #1;
      check("rmw_ready_low2", 32'(req_ready), 32'd0);
      check("rmw_no_trace2", 32'(wtrace_valid), 32'd0);
      @(negedge clk); #1;
      check("rmw_ready_back", 32'(req_ready), 32'd1);
      check("rmw_trace_valid", 32'(wtrace_valid), 32'd1);
      check("rmw_trace_pc", wtrace_pc, pc);
      check("rmw_trace_addr", wtrace_addr, addr & 32'hFFFFFFFC);
      check("rmw_trace_data", wtrace_data, exp_word);
    end
  endtask

  initial begin
    logic [31:0] addr;
    logic [1:0]  sz;
    int          r;
    reset = 1'b1;
    scramble_inputs();
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("ready_in_reset", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_wtrace_valid", 32'(wtrace_valid), 32'd0);
    check("rst_wtrace_pc", wtrace_pc, 32'd0);
    check("rst_wtrace_addr", wtrace_addr, 32'd0);
    check("rst_wtrace_data", wtrace_data, 32'd0);

    // word store / load round trip
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'd0, 1'b0, 32'h100);
    do_req(1'b0, 32'h10, 32'h0, 2'd0, 1'b0, 32'h104);
    // byte store and signed/unsigned byte loads
    do_req(1'b1, 32'h12, 32'h80, 2'd2, 1'b0, 32'h108);
    check("byte_merge_value", model_mem[4], 32'hDE80BEEF);
    do_req(1'b0, 32'h12, 32'h0, 2'd2, 1'b0, 32'h10C);
    do_req(1'b0, 32'h12, 32'h0, 2'd2, 1'b1, 32'h110);
    // half store and half loads
    do_req(1'b1, 32'h10, 32'h8001, 2'd1, 1'b0, 32'h114);
    do_req(1'b0, 32'h10, 32'h0, 2'd1, 1'b0, 32'h118);
    do_req(1'b0, 32'h10, 32'h0, 2'd1, 1'b1, 32'h11C);
    do_req(1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 32'h120);
    do_req(1'b0, 32'h12, 32'h0, 2'd1, 1'b1, 32'h124);
    // misaligned and reserved requests
    do_req(1'b0, 32'h11, 32'h0, 2'd0, 1'b0, 32'h128);
    do_req(1'b1, 32'h13, 32'hFFFF, 2'd1, 1'b0, 32'h12C);
    do_req(1'b0, 32'h10, 32'h0, 2'd3, 1'b0, 32'h130);
    do_req(1'b1, 32'h10, 32'h1234, 2'd3, 1'b0, 32'h134);
    do_req(1'b0, 32'h10, 32'h0, 2'd0, 1'b0, 32'h138);
    // address wrap
    do_req(1'b1, 32'h1000, 32'hAAAA5555, 2'd0, 1'b0, 32'h13C);
    do_req(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h140);
    check("wrap_model", model_mem[0], 32'hAAAA5555);

    // reset during RMW_WR discards the pending write
    do_req(1'b1, 32'h20, 32'h11223344, 2'd0, 1'b0, 32'h200);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h21; req_wdata = 32'h99;
    req_swhb = 2'd2; req_lwhb = 2'd0; req_lunsigned = 1'b0; req_pc = 32'h204;
    #1;
    check("rmw_rst_accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    scramble_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check("rmw_rst_ready_low", 32'(req_ready), 32'd0);
    check("rmw_rst_no_trace", 32'(wtrace_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("rmw_rst_ready_after", 32'(req_ready), 32'd1);
    @(negedge clk); #1;
    check("rmw_rst_no_trace2", 32'(wtrace_valid), 32'd0);
    do_req(1'b0, 32'h20, 32'h0, 2'd0, 1'b0, 32'h208);

    // prime a 16-word window, then random traffic over it with random upper bits
    for (int i = 0; i < 16; i++) do_req(1'b1, 32'(i * 4), $urandom, 2'd0, 1'b0, 32'(i));
    for (int n = 0; n < 300; n++) begin
      addr = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
      r    = $urandom_range(0, 15);
      sz   = (r == 0) ? 2'd3 : 2'(r % 3);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd0) addr = addr & 32'hFFFFFFFC;
        if (sz == 2'd1) addr = addr & 32'hFFFFFFFE;
      end
      do_req(1'($urandom), addr, $urandom, sz, 1'($urandom), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipeline's MEM-stage memory interface.
- Accepts load/store requests, including address, store data, byte/half/word size, load signedness and store PC.
- Owns a word-wide synchronous RAM array and performs sub-word stores by internal read-modify-write.
- Returns size- and sign-adjusted load data and drives a store trace for the testbench.

Parameters:
- XLEN, 32, data and address width.
- AW, 10, word-index width; array holds 2**AW words.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- req_swhb  in  2  store size: 00 word, 01 half, 10 byte, 11 reserved
- req_lwhb  in  2  load size, same encoding as req_swhb
- req_lunsigned  in  1  load zero-extend when 1, sign-extend when 0
- req_pc  in  XLEN  PC of the requesting instruction
- resp_valid  out  1  load response valid
- resp_rdata  out  XLEN  extended load data
- resp_err  out  1  misaligned or reserved-size request
- wtrace_valid  out  1  store committed
- wtrace_pc  out  XLEN  PC of the committed store
- wtrace_addr  out  XLEN  word-aligned address written
- wtrace_data  out  XLEN  full merged word written

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset state: state=IDLE; req_ready=1 after reset, 0 during reset.
  - Outputs cleared: resp_valid, resp_err, wtrace_valid, resp_rdata, wtrace_* all 0.
  - RAM contents are not reset.
- Handshake: a request is accepted on the rising edge where req_valid & req_ready; req_ready = (state==IDLE) & ~reset.
  - Request fields are captured at acceptance; later input changes are ignored.
- Indexing: word index = req_addr[AW+1:2]; upper address bits are ignored, so accesses wrap modulo array size.
  - Byte offset = req_addr[1:0].
- Alignment:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Size 11 is always an error.
- Error path: a misaligned or reserved request is accepted and the state goes IDLE→ERR.
  - ERR lasts 1 cycle with resp_err=1, then returns to IDLE.
  - For a load, resp_valid=1 and resp_rdata=0 in ERR.
  - No RAM write occurs; no trace is emitted.
- States: IDLE, LOAD, RMW_RD, RMW_WR, ERR.
- Load: IDLE→LOAD.
  - The RAM read is issued at acceptance.
  - In LOAD: resp_valid=1; resp_rdata is selected by offset and size, then extended per req_lunsigned.
  - LOAD→IDLE. Latency: response in the cycle after acceptance. Throughput: 1 load per 2 cycles.
- Word store: written into RAM at the acceptance edge; state stays IDLE.
  - wtrace_valid pulses in the next cycle with pc, aligned address and the word.
  - Back-to-back word stores are sustained 1 per cycle.
- Sub-word store: IDLE→RMW_RD (RAM read issued)→RMW_WR→IDLE.
  - The merged word (old word with the target byte/half lanes replaced by the low bits of wdata) is written at the end of RMW_WR.
  - wtrace_valid pulses in the cycle after RMW_WR.
  - req_ready is low in RMW_RD and RMW_WR.
- Read-after-write: a load accepted in the cycle after any store commit returns the new data.
  - No stale read and no forwarding path is required.
- resp_valid and resp_err are single-cycle pulses; resp_rdata holds its last value otherwise.
- Reset mid-operation: at any state, reset returns the block to IDLE at the next edge.
  - A pending RMW write is discarded; words already committed remain.
  - Pending resp/trace pulses are cancelled.
- req_valid while req_ready=0 is ignored. The requester must hold the request until it is accepted.

Test Plan:
- Reset, then word store addr 0x10 data 0xDEADBEEF pc 0x100, then load word 0x10 → wtrace_valid 1 cycle after acceptance with addr 0x10, data 0xDEADBEEF, pc 0x100; load resp_valid 1 cycle after acceptance with 0xDEADBEEF.
- After the above, byte store 0x80 to 0x12, then signed byte load 0x12 and unsigned byte load 0x12 → wtrace_data 0xDE80BEEF; signed load returns 0xFFFFFF80; unsigned load returns 0x00000080; req_ready low exactly 2 cycles during the RMW.
- Half store 0x8001 to 0x10, then signed and unsigned half loads from 0x10 and 0x12 → 0xFFFF8001, 0x00008001, 0xFFFFDE80, 0x0000DE80.
- Misaligned requests: word load 0x11, half store 0x13, load with size 11 → ERR pulse each; load returns resp_rdata 0; RAM unchanged (word load 0x10 returns prior value); no wtrace.
- Wrap: AW=10, word store 0xAAAA5555 at 0x1000, then load 0x0 → returns 0xAAAA5555.
- Reset asserted during RMW_WR of a byte store to 0x20 (previously 0x11223344) → word at 0x20 still reads 0x11223344; no wtrace; req_ready=1 in the cycle after reset deasserts.
